// File: rtl/eviction_buffer.sv
// Write-back buffer between the L1 line port and physical memory.
// Absorbs dirty evictions, forwards buffered lines, drains when idle.
module eviction_buffer #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [15:0]  mem_address,
  input  logic [127:0] mem_wdata,
  output logic [127:0] mem_rdata,
  output logic         mem_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp,
  output logic         empty,
  output logic         full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE, READ_MEM, DRAIN, RESP
  } state_t;

  state_t           r_state;
  logic [11:0]      r_tag  [DEPTH];
  logic [127:0]     r_data [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic [127:0]     r_rdata;
  logic             r_resp;
  logic             r_pread;
  logic             r_pwrite;

  logic [11:0]   w_tag;
  logic          w_hit;
  logic [PW-1:0] w_hit_idx;
  logic          w_unused;

  assign w_tag    = mem_address[15:4];
  assign w_unused = ^mem_address[3:0];

  // Tags are unique, so at most one entry can match.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && r_tag[i] == w_tag) begin
        w_hit     = 1'b1;
        w_hit_idx = PW'(i);
      end
    end
  end

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_valid  <= '0;
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_rdata  <= '0;
      r_resp   <= 1'b0;
      r_pread  <= 1'b0;
      r_pwrite <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (mem_read) begin
            if (w_hit) begin
              r_rdata <= r_data[w_hit_idx];
              r_resp  <= 1'b1;
              r_state <= RESP;
            end else begin
              r_pread <= 1'b1;
              r_state <= READ_MEM;
            end
          end else if (mem_write) begin
            if (w_hit) begin
              r_data[w_hit_idx] <= mem_wdata;
              r_resp  <= 1'b1;
              r_state <= RESP;
            end else if (!full) begin
              r_tag[r_tail]   <= w_tag;
              r_data[r_tail]  <= mem_wdata;
              r_valid[r_tail] <= 1'b1;
              r_tail  <= inc(r_tail);
              r_count <= r_count + 1'b1;
              r_resp  <= 1'b1;
              r_state <= RESP;
            end else begin
              r_pwrite <= 1'b1;
              r_state  <= DRAIN;
            end
          end else if (!empty) begin
            r_pwrite <= 1'b1;
            r_state  <= DRAIN;
          end
        end
        READ_MEM: begin
          if (pmem_resp) begin
            r_rdata <= pmem_rdata;
            r_pread <= 1'b0;
            r_resp  <= 1'b1;
            r_state <= RESP;
          end
        end
        DRAIN: begin
          if (pmem_resp) begin
            r_pwrite        <= 1'b0;
            r_valid[r_head] <= 1'b0;
            r_head  <= inc(r_head);
            r_count <= r_count - 1'b1;
            r_state <= IDLE;
          end
        end
        RESP: begin
          r_resp  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_rdata  = r_rdata;
  assign mem_resp   = r_resp;
  assign pmem_read  = r_pread;
  assign pmem_write = r_pwrite;
  assign pmem_wdata = r_data[r_head];
  assign pmem_address = (r_state == READ_MEM)
                      ? {w_tag, 4'h0}
                      : {r_tag[r_head], 4'h0};
  assign empty = (r_count == '0);
  assign full  = (r_count == CW'(DEPTH));

endmodule

// File: tb/tb_eviction_buffer.sv
// Scoreboard bench for eviction_buffer with a fixed-latency
// memory model on the pmem side.
module tb_eviction_buffer;
  localparam int LAT = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         mem_read;
  logic         mem_write;
  logic [15:0]  mem_address;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  logic         empty;
  logic         full;

  always #5 clk = ~clk;

  eviction_buffer #(.DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_resp    (mem_resp),
    .pmem_read   (pmem_read),
    .pmem_write  (pmem_write),
    .pmem_address(pmem_address),
    .pmem_wdata  (pmem_wdata),
    .pmem_rdata  (pmem_rdata),
    .pmem_resp   (pmem_resp),
    .empty       (empty),
    .full        (full)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_pwr = 0;
  int n_prd = 0;

  logic [127:0] mem [logic [15:0]];
  logic [143:0] exp_wr [$];
  logic [127:0] exp_rd [$];

  task automatic check(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pat(
    input logic [15:0] a
  );
    return {8{a}};
  endfunction

  function automatic logic [127:0] dat(
    input int k
  );
    return {4{32'hD0D0_0000 | k}};
  endfunction

  always @(posedge clk)
    assert (reset || !(mem_read && mem_write))
      else $error("illegal: mem_read and mem_write both high");

  initial begin : pmem_model
    int cnt;
    logic [143:0] e;
    cnt = 0;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (reset) begin
        cnt = 0;
      end else if (pmem_read || pmem_write) begin
        cnt++;
        if (cnt == LAT) begin
          pmem_resp = 1'b1;
          if (pmem_write) begin
            n_pwr++;
            if (exp_wr.size() == 0) begin
              check("drain_unexp",
                    {112'd0, pmem_address}, '1);
            end else begin
              e = exp_wr.pop_front();
              check("drain_addr", {112'd0, pmem_address},
                    {112'd0, e[143:128]});
              check("drain_data", pmem_wdata, e[127:0]);
            end
            mem[pmem_address] = pmem_wdata;
          end else begin
            n_prd++;
            pmem_rdata = mem.exists(pmem_address)
                       ? mem[pmem_address]
                       : pat(pmem_address);
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic req(
    input bit           rd,
    input logic [15:0]  a,
    input logic [127:0] d,
    input int           exp_lat,
    input string        tag
  );
    int cyc = 0;
    mem_address = a;
    mem_wdata   = d;
    mem_read    = rd;
    mem_write   = !rd;
    do begin
      @(negedge clk);
      cyc++;
    end while (!mem_resp && cyc < 100);
    check({tag, "_lat"}, cyc, exp_lat);
    if (rd && mem_resp && exp_rd.size() > 0)
      check({tag, "_rdata"}, mem_rdata, exp_rd.pop_front());
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic wait_drained(input string tag);
    int cyc = 0;
    while (!(empty && !pmem_write && !pmem_read)
           && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_empty"}, empty, 1);
    check({tag, "_expq"}, exp_wr.size(), 0);
  endtask

  initial begin
    int pw;
    int pr;
    int cyc;
    reset = 1'b1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_address = '0;
    mem_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_resp", mem_resp, 0);
    check("rst_rdata", mem_rdata, 0);
    check("rst_pread", pmem_read, 0);
    check("rst_pwrite", pmem_write, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    reset = 1'b0;
    @(negedge clk);

    // 1: buffered write then idle drain
    exp_wr.push_back({16'h1230, dat(1)});
    req(0, 16'h1230, dat(1), 1, "t1w");
    check("t1_nopw", pmem_write, 0);
    check("t1_nopr", pmem_read, 0);
    check("t1_notempty", empty, 0);
    wait_drained("t1");

    // 2: forward a buffered line on read
    exp_wr.push_back({16'h4560, dat(2)});
    pr = n_prd;
    req(0, 16'h4560, dat(2), 1, "t2w");
    exp_rd.push_back(dat(2));
    req(1, 16'h4568, '0, 2, "t2r");
    wait_drained("t2");
    check("t2_nopread", n_prd, pr);

    // 3: fill, overflow costs one drain, tail wraps
    for (int i = 1; i <= 5; i++)
      exp_wr.push_back({16'(i * 16), dat(16 + i)});
    req(0, 16'h0010, dat(17), 1, "t3w1");
    req(0, 16'h0020, dat(18), 2, "t3w2");
    req(0, 16'h0030, dat(19), 2, "t3w3");
    req(0, 16'h0040, dat(20), 2, "t3w4");
    check("t3_full4", full, 1);
    req(0, 16'h0050, dat(21), 3 + LAT, "t3w5");
    check("t3_full5", full, 1);
    check("t3_ndrain", exp_wr.size(), 4);
    wait_drained("t3");

    // 4: rewrite of a buffered line updates in place
    exp_wr.push_back({16'h0700, dat(4)});
    pw = n_pwr;
    req(0, 16'h0700, dat(3), 1, "t4w1");
    req(0, 16'h0700, dat(4), 2, "t4w2");
    check("t4_full", full, 0);
    wait_drained("t4");
    check("t4_ndrain", n_pwr - pw, 1);

    // 5: read miss pre-empts pending drains
    exp_wr.push_back({16'hA000, dat(10)});
    exp_wr.push_back({16'hB000, dat(11)});
    req(0, 16'hA000, dat(10), 1, "t5w1");
    req(0, 16'hB000, dat(11), 2, "t5w2");
    pw = n_pwr;
    exp_rd.push_back(pat(16'h9990));
    req(1, 16'h9990, '0, 2 + LAT, "t5r");
    check("t5_read_first", n_pwr, pw);
    wait_drained("t5");

    // 6: reset during a drain
    req(0, 16'hC000, dat(12), 1, "t6w");
    cyc = 0;
    while (!pmem_write && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("t6_draining", pmem_write, 1);
    pw = n_pwr;
    reset = 1'b1;
    @(negedge clk);
    check("t6_pwrite", pmem_write, 0);
    check("t6_pread", pmem_read, 0);
    check("t6_empty", empty, 1);
    check("t6_rdata", mem_rdata, 0);
    check("t6_resp", mem_resp, 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("t6_nodrain", n_pwr, pw);
    check("t6_empty2", empty, 1);

    $display("Result: errors=%0d of %0d checks",
             n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/eviction_buffer.md
Name: eviction_buffer

Overview:
- Write-back buffer between the L1 cache's memory-side port (MAR/MDR line interface) and physical memory.
- Absorbs evicted dirty 128-bit lines in one cycle, so the cache's refill read can go to memory first. Buffered lines are drained to memory when the cache is idle.
- Line reads that hit a buffered line are forwarded from the buffer, which keeps memory ordering coherent.

Parameters:
DEPTH, 4, number of line entries (>=1); occupancy counter width is $clog2(DEPTH+1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
mem_read  in  1  cache line-read request, held until mem_resp
mem_write  in  1  cache line-write (eviction) request, held until mem_resp
mem_address  in  16 (lc3b_word)  cache line address; bits [3:0] ignored
mem_wdata  in  128 (lc3b_8words)  eviction line data
mem_rdata  out  128 (lc3b_8words)  registered read data, valid while mem_resp=1
mem_resp  out  1  one-cycle completion pulse to cache
pmem_read  out  1  physical memory read strobe
pmem_write  out  1  physical memory write strobe
pmem_address  out  16  line address to memory, bits [3:0]=0
pmem_wdata  out  128  head-entry data
pmem_rdata  in  128  memory read data
pmem_resp  in  1  memory completion
empty  out  1  buffer holds no lines
full  out  1  occupancy == DEPTH

Behaviour:
- Storage: circular FIFO of DEPTH entries {tag[15:4], data[127:0]}, with head and tail pointers that wrap modulo DEPTH, plus a count.
- Tags in the FIFO are always unique.
- Reset:
  - state=IDLE, count=0, head=tail=0.
  - mem_resp=0, mem_rdata=0, pmem_read=0, pmem_write=0, empty=1, full=0.
  - Reset mid-transaction abandons any in-flight pmem operation; memory is reset alongside.
- FSM states: IDLE, READ_MEM, DRAIN, RESP. All outputs except pmem_address and pmem_wdata are Moore outputs.
- IDLE: first matching rule applies.
  1. mem_read, tag matches entry k: mem_rdata<=data[k] -> RESP (forward, 1-cycle latency).
  2. mem_read, no match -> READ_MEM.
  3. mem_write, tag matches entry k: data[k]<=mem_wdata in place; no reorder, count unchanged -> RESP.
  4. mem_write, no match, !full: push at tail, count+1 -> RESP.
  5. mem_write, no match, full -> DRAIN.
  6. No request, count>0 -> DRAIN.
  7. Otherwise stay in IDLE.
- mem_read and mem_write both high is illegal; the read wins. The bench flags it as an assertion error.
- READ_MEM:
  - pmem_read=1, pmem_address={mem_address[15:4],4'b0}.
  - On pmem_resp: mem_rdata<=pmem_rdata -> RESP.
- DRAIN:
  - pmem_write=1, pmem_address={head.tag,4'b0}, pmem_wdata=head.data.
  - On pmem_resp: pop head, count-1 -> IDLE, which re-evaluates any pending request.
  - A drain is never aborted; a cache request arriving mid-drain waits for it to finish.
- RESP: mem_resp=1 for exactly one cycle -> IDLE. The cache drops its request the following cycle.
- Priority: cache reads pre-empt idle draining, but only at the IDLE decision point.
- A write to a full buffer costs one drain, then the write is accepted via rule 4.
- empty and full are combinational from count.
- Latency:
  - Forwarded read or buffered write: mem_resp in cycle t+1 after the request is seen in IDLE at cycle t.
  - Read miss: memory latency + 2 cycles.
- Ordering invariant: memory never receives a stale line. Every read address present in the buffer is forwarded.

Test Plan:
1. Reset, then mem_write addr 0x1230, data D1 -> mem_resp at t+1; no pmem activity that cycle; count=1. Idle drain then writes 0x1230/D1 to pmem; empty=1.
2. Write 0x4560/D2, then immediately mem_read 0x4568 -> mem_rdata=D2 at t+1; pmem_read never asserted.
3. DEPTH=4: hold cache requests back-to-back (no idle gaps) to write 0x0010, 0x0020, 0x0030, 0x0040, so full=1. Fifth write 0x0050 -> pmem_write of 0x0010 first, then 0x0050 accepted; tail wrap verified; FIFO order 0x20,0x30,0x40,0x50.
4. Write 0x0700/D3, then write 0x0700/D4 -> count stays 1. Drain writes D4 only.
5. Buffer holds 2 lines; mem_read 0x9990 (miss) issued while in IDLE -> pmem_read before any drain. mem_rdata = memory data; drains follow.
6. Assert reset during DRAIN with pmem_resp pending -> next cycle all strobes 0, empty=1, mem_rdata=0.
